// File: rtl/chess_pkg.sv
// Shared types, colours and helpers for the chess-board sprite pixel pipeline.
package chess_pkg;

  typedef logic [5:0]  sq_idx_t;       // square index, row*8+col
  typedef logic [4:0]  sprite_code_t;  // sprite code, 0 = empty square
  typedef logic [2:0]  pal_idx_t;      // palette index returned by the sprite ROM
  typedef logic [23:0] rgb_t;          // {red, green, blue}

  // Sprite codes
  localparam sprite_code_t EMPTY    = 5'd0;
  localparam sprite_code_t W_PAWN   = 5'd1;
  localparam sprite_code_t W_KNIGHT = 5'd2;
  localparam sprite_code_t W_BISHOP = 5'd3;
  localparam sprite_code_t W_ROOK   = 5'd4;
  localparam sprite_code_t W_QUEEN  = 5'd5;
  localparam sprite_code_t W_KING   = 5'd6;
  localparam sprite_code_t B_PAWN   = 5'd7;
  localparam sprite_code_t B_KNIGHT = 5'd8;
  localparam sprite_code_t B_BISHOP = 5'd9;
  localparam sprite_code_t B_ROOK   = 5'd10;
  localparam sprite_code_t B_QUEEN  = 5'd11;
  localparam sprite_code_t B_KING   = 5'd12;

  // Palette; entry 0 is never displayed because index 0 means transparent
  localparam rgb_t PALETTE [8] = '{
    24'h000000, 24'hFFFFFF, 24'h101010, 24'hC0C0C0,
    24'hFF0000, 24'h0000FF, 24'h808080, 24'h00FF00
  };

  localparam rgb_t LIGHT_SQ     = 24'hF0D9B5;
  localparam rgb_t DARK_SQ      = 24'hB58863;
  localparam rgb_t BG_COLOR     = 24'h202020;
  localparam rgb_t CURSOR_COLOR = 24'hFFFF00;

  // Square index along one axis plus the offset inside that square
  typedef struct packed {
    logic [2:0] idx;
    logic [5:0] off;
  } axis_split_t;

  // Per-pixel flags travelling down the pipeline alongside the ROM lookup
  typedef struct packed {
    logic in_board;
    logic parity;     // (row ^ col)[0], 0 = light square
    logic cur_hit;    // pixel lies on the cursor square
    logic edge_px;    // pixel lies in the 2-pixel rim of its square
    logic blank;      // 1 = active video
    logic code_zero;  // square holds no sprite
  } pix_flags_t;

  // Compare-subtract split of a board-relative coordinate into square index
  // and offset; avoids a divider. Only meaningful for v < 8*sq, sq <= 64.
  function automatic axis_split_t split_axis(input logic [9:0] v, input logic [9:0] sq);
    axis_split_t r;
    logic [9:0]  thr;
    r.idx = '0;
    r.off = v[5:0];
    thr   = '0;
    for (int i = 1; i < 8; i++) begin
      thr = thr + sq;
      if (v >= thr) begin
        r.idx = 3'(i);
        r.off = 6'(v - thr);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/sprite_pixel_pipe_if.sv
// Video/board bus between the pixel pipeline and its driver (scan-out, board writer, ROM).
interface sprite_pixel_pipe_if;
  import chess_pkg::*;

  logic [9:0]   DrawX;
  logic [9:0]   DrawY;
  logic         blank_in;
  logic         wr_en;
  sq_idx_t      wr_sq;
  sprite_code_t wr_code;
  sq_idx_t      cursor_sq;
  logic [11:0]  pixel_address;
  sprite_code_t sprite_address;
  pal_idx_t     rom_data;
  logic [7:0]   Red;
  logic [7:0]   Green;
  logic [7:0]   Blue;
  logic         blank_out;

  modport master (
    output DrawX, DrawY, blank_in, wr_en, wr_sq, wr_code, cursor_sq, rom_data,
    input  pixel_address, sprite_address, Red, Green, Blue, blank_out
  );

  modport slave (
    input  DrawX, DrawY, blank_in, wr_en, wr_sq, wr_code, cursor_sq, rom_data,
    output pixel_address, sprite_address, Red, Green, Blue, blank_out
  );
endinterface

// File: rtl/sprite_pixel_pipe_board_regfile.sv
// 64-entry board state: one synchronous write port, one combinational read port.
module board_regfile
  import chess_pkg::*;
(
  input  logic         Clk,
  input  logic         Reset_n,
  input  logic         wr_en_i,
  input  sq_idx_t      wr_sq_i,
  input  sprite_code_t wr_code_i,
  input  sq_idx_t      rd_sq_i,
  output sprite_code_t rd_code_o
);

  sprite_code_t board_q [64];

  for (genvar gi = 0; gi < 64; gi++) begin : g_entry
    // Each square clears on reset and loads when addressed by a write
    always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n)
        board_q[gi] <= EMPTY;
      else if (wr_en_i && (wr_sq_i == 6'(gi)))
        board_q[gi] <= wr_code_i;
    end
  end

  // Read sees the pre-edge contents, so a same-cycle write returns the old code
  assign rd_code_o = board_q[rd_sq_i];

endmodule

// File: rtl/sprite_pixel_pipe.sv
// Three-stage chess-board pixel pipeline: locate square, fetch sprite, colour pixel.
module sprite_pixel_pipe
  import chess_pkg::*;
#(
  parameter int BOARD_X0 = 80,
  parameter int BOARD_Y0 = 0,
  parameter int SQ       = 60
) (
  input logic               Clk,
  input logic               Reset_n,
  sprite_pixel_pipe_if.slave bus
);

  // 11-bit bounds so the right/bottom edge cannot wrap
  localparam logic [10:0] X_BEG = 11'(BOARD_X0);
  localparam logic [10:0] X_END = 11'(BOARD_X0 + 8 * SQ);
  localparam logic [10:0] Y_BEG = 11'(BOARD_Y0);
  localparam logic [10:0] Y_END = 11'(BOARD_Y0 + 8 * SQ);

  logic         in_x, in_y;
  logic [9:0]   rel_x, rel_y;
  axis_split_t  sx, sy;
  sq_idx_t      rd_sq;
  sprite_code_t rd_code;

  pix_flags_t   s1_d, s1_q, s2_q;
  logic [11:0]  pix_addr_d, pix_addr_q;
  sprite_code_t spr_d, spr_q;
  rgb_t         rgb_d, rgb_q;
  logic         blank_out_q;

  // Bounds are checked before subtraction, so wrapped offsets are never used
  assign in_x  = ({1'b0, bus.DrawX} >= X_BEG) && ({1'b0, bus.DrawX} < X_END);
  assign in_y  = ({1'b0, bus.DrawY} >= Y_BEG) && ({1'b0, bus.DrawY} < Y_END);
  assign rel_x = bus.DrawX - 10'(BOARD_X0);
  assign rel_y = bus.DrawY - 10'(BOARD_Y0);
  assign sx    = split_axis(rel_x, 10'(SQ));
  assign sy    = split_axis(rel_y, 10'(SQ));
  assign rd_sq = {sy.idx, sx.idx};

  board_regfile u_board (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .wr_en_i   (bus.wr_en),
    .wr_sq_i   (bus.wr_sq),
    .wr_code_i (bus.wr_code),
    .rd_sq_i   (rd_sq),
    .rd_code_o (rd_code)
  );

  // Stage 1 next state: square lookup, ROM address and per-pixel flags
  always_comb begin
    s1_d       = '0;
    pix_addr_d = '0;
    spr_d      = EMPTY;
    s1_d.blank = bus.blank_in;
    if (in_x && in_y) begin
      s1_d.in_board  = 1'b1;
      s1_d.parity    = sy.idx[0] ^ sx.idx[0];
      s1_d.cur_hit   = (rd_sq == bus.cursor_sq);
      s1_d.edge_px   = (sx.off <= 6'd1) || (sx.off >= 6'(SQ - 2)) ||
                       (sy.off <= 6'd1) || (sy.off >= 6'(SQ - 2));
      s1_d.code_zero = (rd_code == EMPTY);
      spr_d          = rd_code;
      pix_addr_d     = 12'(sy.off) * 12'(SQ) + 12'(sx.off);
    end
  end

  // Stage 1 registers: ROM address plus flags
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      s1_q       <= '0;
      pix_addr_q <= '0;
      spr_q      <= EMPTY;
    end else begin
      s1_q       <= s1_d;
      pix_addr_q <= pix_addr_d;
      spr_q      <= spr_d;
    end
  end

  // Stage 2 registers: flags delayed to line up with the ROM's data
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) s2_q <= '0;
    else          s2_q <= s1_q;
  end

  // Stage 3 next state: colour selection in priority order
  always_comb begin
    rgb_d = '0;
    if (!s2_q.blank)
      rgb_d = '0;
    else if (!s2_q.in_board)
      rgb_d = BG_COLOR;
    else if (s2_q.cur_hit && s2_q.edge_px)
      rgb_d = CURSOR_COLOR;
    else if (s2_q.code_zero || (bus.rom_data == 3'd0))
      rgb_d = s2_q.parity ? DARK_SQ : LIGHT_SQ;
    else
      rgb_d = PALETTE[bus.rom_data];
  end

  // Stage 3 registers: final colour and matching blank
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rgb_q       <= '0;
      blank_out_q <= 1'b0;
    end else begin
      rgb_q       <= rgb_d;
      blank_out_q <= s2_q.blank;
    end
  end

  assign bus.pixel_address  = pix_addr_q;
  assign bus.sprite_address = spr_q;
  assign bus.Red            = rgb_q[23:16];
  assign bus.Green          = rgb_q[15:8];
  assign bus.Blue           = rgb_q[7:0];
  assign bus.blank_out      = blank_out_q;

endmodule

// File: tb/tb_sprite_pixel_pipe.sv
// Directed bench for sprite_pixel_pipe: one task per scenario, inline checks.
module tb_sprite_pixel_pipe;

  localparam logic [23:0] C_BLACK = 24'h000000;
  localparam logic [23:0] C_LIGHT = 24'hF0D9B5;
  localparam logic [23:0] C_DARK  = 24'hB58863;
  localparam logic [23:0] C_BG    = 24'h202020;
  localparam logic [23:0] C_CUR   = 24'hFFFF00;
  localparam logic [23:0] C_PAL3  = 24'hC0C0C0;
  localparam logic [23:0] C_PAL4  = 24'hFF0000;

  logic Clk;
  logic Reset_n;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [23:0] rgb;

  sprite_pixel_pipe_if bus();

  sprite_pixel_pipe #(.BOARD_X0(80), .BOARD_Y0(0), .SQ(60)) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  assign rgb = {bus.Red, bus.Green, bus.Blue};

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic step(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic set_px(input logic [9:0] x, input logic [9:0] y, input logic b, input logic [2:0] rom);
    bus.DrawX    = x;
    bus.DrawY    = y;
    bus.blank_in = b;
    bus.rom_data = rom;
  endtask

  task automatic test_reset();
    Reset_n       = 1'b0;
    bus.wr_en     = 1'b0;
    bus.wr_sq     = '0;
    bus.wr_code   = '0;
    bus.cursor_sq = 6'd63;
    set_px(10'd200, 10'd200, 1'b1, 3'd5);
    #12;
    n_cmp++; if (rgb !== C_BLACK) begin n_bad++; $display("FAIL reset_rgb: got %h expected %h", rgb, C_BLACK); end
    n_cmp++; if (bus.blank_out !== 1'b0) begin n_bad++; $display("FAIL reset_blank: got %b expected 0", bus.blank_out); end
    n_cmp++; if ({bus.pixel_address, bus.sprite_address} !== 17'd0) begin n_bad++;
      $display("FAIL reset_addr: got pa=%0d sa=%0d expected 0/0", bus.pixel_address, bus.sprite_address); end
    $display("reset: rgb=%h pa=%0d sa=%0d", rgb, bus.pixel_address, bus.sprite_address);
    @(posedge Clk); #1;
    Reset_n = 1'b1;
  endtask

  task automatic test_first_pixel();
    set_px(10'd80, 10'd0, 1'b1, 3'd0);
    step(1);
    n_cmp++; if (bus.pixel_address !== 12'd0) begin n_bad++; $display("FAIL first_pa: got %0d expected 0", bus.pixel_address); end
    n_cmp++; if (bus.sprite_address !== 5'd0) begin n_bad++; $display("FAIL first_sa: got %0d expected 0", bus.sprite_address); end
    step(2);
    n_cmp++; if (rgb !== C_LIGHT) begin n_bad++; $display("FAIL first_rgb: got %h expected %h", rgb, C_LIGHT); end
    n_cmp++; if (bus.blank_out !== 1'b1) begin n_bad++; $display("FAIL first_blank: got %b expected 1", bus.blank_out); end
    $display("px (80,0): rgb=%h", rgb);
  endtask

  task automatic test_sprite();
    bus.wr_en = 1'b1; bus.wr_sq = 6'd0; bus.wr_code = 5'd5;
    step(1);
    bus.wr_en = 1'b0;
    set_px(10'd139, 10'd59, 1'b1, 3'd3);
    step(1);
    n_cmp++; if (bus.pixel_address !== 12'd3599) begin n_bad++; $display("FAIL sprite_pa: got %0d expected 3599", bus.pixel_address); end
    n_cmp++; if (bus.sprite_address !== 5'd5) begin n_bad++; $display("FAIL sprite_sa: got %0d expected 5", bus.sprite_address); end
    step(2);
    n_cmp++; if (rgb !== C_PAL3) begin n_bad++; $display("FAIL sprite_rgb: got %h expected %h", rgb, C_PAL3); end
    $display("px (139,59): rgb=%h", rgb);
  endtask

  task automatic test_square_bg();
    set_px(10'd140, 10'd0, 1'b1, 3'd0);
    step(1);
    n_cmp++; if (bus.sprite_address !== 5'd0) begin n_bad++; $display("FAIL dark_sa: got %0d expected 0", bus.sprite_address); end
    step(2);
    n_cmp++; if (rgb !== C_DARK) begin n_bad++; $display("FAIL dark_rgb: got %h expected %h", rgb, C_DARK); end
    set_px(10'd79, 10'd0, 1'b1, 3'd3);
    step(1);
    n_cmp++; if (bus.sprite_address !== 5'd0) begin n_bad++; $display("FAIL left_sa: got %0d expected 0", bus.sprite_address); end
    step(2);
    n_cmp++; if (rgb !== C_BG) begin n_bad++; $display("FAIL left_rgb: got %h expected %h", rgb, C_BG); end
    set_px(10'd560, 10'd100, 1'b1, 3'd3);
    step(3);
    n_cmp++; if (rgb !== C_BG) begin n_bad++; $display("FAIL right_rgb: got %h expected %h", rgb, C_BG); end
    set_px(10'd100, 10'd480, 1'b1, 3'd3);
    step(3);
    n_cmp++; if (rgb !== C_BG) begin n_bad++; $display("FAIL bottom_rgb: got %h expected %h", rgb, C_BG); end
    set_px(10'd559, 10'd479, 1'b1, 3'd0);
    step(1);
    n_cmp++; if (bus.pixel_address !== 12'd3599) begin n_bad++; $display("FAIL corner_pa: got %0d expected 3599", bus.pixel_address); end
    step(2);
    n_cmp++; if (rgb !== C_CUR) begin n_bad++; $display("FAIL corner_rgb: got %h expected %h", rgb, C_CUR); end
    set_px(10'd100, 10'd100, 1'b0, 3'd3);
    step(3);
    n_cmp++; if (rgb !== C_BLACK) begin n_bad++; $display("FAIL blank_rgb: got %h expected %h", rgb, C_BLACK); end
    n_cmp++; if (bus.blank_out !== 1'b0) begin n_bad++; $display("FAIL blank_out: got %b expected 0", bus.blank_out); end
    $display("px edges/background done: last rgb=%h", rgb);
  endtask

  task automatic test_cursor();
    bus.cursor_sq = 6'd9;
    set_px(10'd141, 10'd61, 1'b1, 3'd0);
    step(3);
    n_cmp++; if (rgb !== C_CUR) begin n_bad++; $display("FAIL cursor_rim_rgb: got %h expected %h", rgb, C_CUR); end
    set_px(10'd145, 10'd65, 1'b1, 3'd3);
    step(1);
    n_cmp++; if (bus.pixel_address !== 12'd305) begin n_bad++; $display("FAIL cursor_in_pa: got %0d expected 305", bus.pixel_address); end
    step(2);
    n_cmp++; if (rgb !== C_LIGHT) begin n_bad++; $display("FAIL cursor_in_rgb: got %h expected %h", rgb, C_LIGHT); end
    $display("px (145,65): rgb=%h", rgb);
    bus.cursor_sq = 6'd63;
  endtask

  task automatic test_back_to_back();
    set_px(10'd80, 10'd0, 1'b1, 3'd0);
    bus.wr_en = 1'b1; bus.wr_sq = 6'd0; bus.wr_code = 5'd7;
    step(1);
    bus.wr_en = 1'b0;
    n_cmp++; if (bus.sprite_address !== 5'd5) begin n_bad++; $display("FAIL rw_old_sa: got %0d expected 5", bus.sprite_address); end
    step(1);
    bus.rom_data = 3'd4;
    n_cmp++; if (bus.sprite_address !== 5'd7) begin n_bad++; $display("FAIL rw_new_sa: got %0d expected 7", bus.sprite_address); end
    step(2);
    n_cmp++; if (rgb !== C_PAL4) begin n_bad++; $display("FAIL rw_rgb: got %h expected %h", rgb, C_PAL4); end
    $display("px (80,0) after write: rgb=%h", rgb);
  endtask

  task automatic test_reset_mid();
    #2;
    Reset_n = 1'b0;
    #1;
    n_cmp++; if (rgb !== C_BLACK) begin n_bad++; $display("FAIL midrst_rgb: got %h expected %h", rgb, C_BLACK); end
    n_cmp++; if ({bus.blank_out, bus.pixel_address, bus.sprite_address} !== 18'd0) begin n_bad++;
      $display("FAIL midrst_out: got blank=%b pa=%0d sa=%0d expected 0/0/0", bus.blank_out, bus.pixel_address, bus.sprite_address); end
    step(1);
    Reset_n = 1'b1;
    step(1);
    n_cmp++; if (bus.sprite_address !== 5'd0) begin n_bad++; $display("FAIL midrst_sa: got %0d expected 0", bus.sprite_address); end
    step(2);
    n_cmp++; if (rgb !== C_LIGHT) begin n_bad++; $display("FAIL midrst_rgb_after: got %h expected %h", rgb, C_LIGHT); end
    $display("px (80,0) after reset: rgb=%h", rgb);
  endtask

  initial begin
    test_reset();
    test_first_pixel();
    test_sprite();
    test_square_bg();
    test_cursor();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sprite_pixel_pipe.md
SPRITE_PIXEL_PIPE -- requirements
Module: sprite_pixel_pipe

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- BOARD_X0, 80: board left edge, pixels.
- BOARD_Y0, 0: board top edge, pixels.
- SQ, 60: square side, pixels.
REQ-002 Ports (name, direction, width, meaning), one per line:
- Clk, in, 1: single clock.
- Reset_n, in, 1: asynchronous active-low reset.
- DrawX, in, 10: current pixel x.
- DrawY, in, 10: current pixel y.
- blank_in, in, 1: 1 = active video.
- wr_en, in, 1: board write strobe.
- wr_sq, in, 6: square index, row*8+col.
- wr_code, in, 5: sprite code; 0 = empty.
- cursor_sq, in, 6: highlighted square.
- pixel_address, out, 12: offset into the sprite ROM.
- sprite_address, out, 5: sprite code sent to the ROM.
- rom_data, in, 3: palette index returned by the ROM, 1 cycle after the address.
- Red, out, 8: pixel red.
- Green, out, 8: pixel green.
- Blue, out, 8: pixel blue.
- blank_out, out, 1: blank_in delayed to align with RGB.

Function
REQ-003 The block SHALL hold a 64x5 board register file, written on the Clk edge when wr_en=1.
REQ-004 Stage 1 (registered) SHALL compute in_board, col/row = (DrawX-BOARD_X0)/SQ and (DrawY-BOARD_Y0)/SQ (0..7), and offsets ox/oy (0..SQ-1).
- No dividers: use compare-subtract or counters.
REQ-005 Stage 1 SHALL register pixel_address = oy*SQ+ox (range 0..3599, 12-bit, no overflow).
REQ-006 Stage 1 SHALL register sprite_address = board[row*8+col] when in_board, else 0.
REQ-007 Stage 2 SHALL carry in_board, parity (row^col)[0], the cursor-hit flag, the cursor-border flag and blank_in, so they align with rom_data.
REQ-008 Stage 3 SHALL register the RGB outputs. Priority, highest first:
- blank=0 -> 0x000000.
- !in_board -> BG_COLOR.
- cursor-border pixel, i.e. ox or oy in {0,1,SQ-2,SQ-1} on cursor_sq -> CURSOR_COLOR.
- sprite code 0 or rom_data 0 -> LIGHT_SQ or DARK_SQ by parity (0 = light).
- otherwise -> PALETTE[rom_data].
REQ-009 Latency from DrawX/DrawY/blank_in to Red/Green/Blue/blank_out SHALL be exactly 3 Clk cycles, every cycle, with no stalls.
REQ-010 A write in the same cycle as a stage-1 read of the same square SHALL return the old code; the new code is visible from the next cycle.
REQ-011 Pixels with DrawX < BOARD_X0 or DrawX >= BOARD_X0+8*SQ, and likewise for y, SHALL be treated as !in_board.
- Unsigned subtraction SHALL NOT wrap into the board.
REQ-012 cursor_sq SHALL be sampled in stage 1, so a change takes effect on the next pixel.

Reset
REQ-013 While Reset_n=0, all of the following SHALL be 0 asynchronously:
- pipeline registers;
- pixel_address and sprite_address;
- Red, Green, Blue and blank_out;
- all 64 board entries.
REQ-014 Reset asserted mid-frame SHALL force 0 outputs on the next cycle.
- After release, valid output resumes 3 cycles after the first sampled input.

Structure
REQ-015 The shared package chess_pkg SHALL hold:
- sprite code constants, including EMPTY=0;
- the 8-entry 24-bit PALETTE;
- LIGHT_SQ, DARK_SQ, BG_COLOR and CURSOR_COLOR;
- the square-index type.
REQ-016 The board register file SHALL be one sub-module, board_regfile: 64x5, one write port, one combinational read port.

Verification
REQ-017 The bench SHALL cover these directed scenarios (stimulus -> required response):
1. Reset, then DrawX=80, DrawY=0, blank=1 -> one cycle later pixel_address=0, sprite_address=0; three cycles later RGB=LIGHT_SQ (cursor_sq set to 63).
2. Write sq 0 with code 5, then DrawX=139, DrawY=59 -> pixel_address=3599, sprite_address=5; with rom_data=3, RGB=PALETTE[3] at cycle 3.
3. DrawX=140, DrawY=0 (sq 1, dark) with rom_data=0 -> DARK_SQ; DrawX=79 -> BG_COLOR, sprite_address=0.
4. cursor_sq=9, DrawX=141, DrawY=61 -> CURSOR_COLOR; DrawX=145, DrawY=65 -> normal square colour.
5. wr_en to sq 0 in the same cycle as a read of sq 0 -> old code returned; the following cycle returns the new code.
6. Reset_n pulsed low mid-line -> all outputs 0 asynchronously; the board is cleared (every square renders empty).
